// File: rtl/clk_freq_meter_pkg.sv
// Shared types and helpers for the clock frequency meter.
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int unsigned gate_cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/clk_freq_meter_sync_edge_detect.sv
// Synchroniser for the asynchronous measured signal plus a registered rising-edge pulse.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Registered pulse gives a fixed SYNC_STAGES+1 cycle latency from din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_p <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts meas_i rising edges over GATE_CYCLES reference cycles.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 12_000_000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK_i,
    input  logic             RST_N_i,
    input  logic             en_i,
    input  logic             cont_i,
    input  logic             start_i,
    input  logic             meas_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             alive_o
);

    localparam int unsigned     GW        = gate_cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t           state, state_nxt;
    logic             edge_p;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_inc;
    logic             ovf_win, ovf_inc;
    logic             gate_last;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (CLK_i),
        .rst_n  (RST_N_i),
        .din    (meas_i),
        .edge_p (edge_p)
    );

    always_comb begin
        gate_last = (gate_cnt == GATE_LAST);
        edge_inc  = edge_cnt;
        ovf_inc   = ovf_win;
        if (edge_p) begin
            if (&edge_cnt) ovf_inc  = 1'b1;
            else           edge_inc = edge_cnt + 1'b1;
        end

        state_nxt = state;
        case (state)
            ST_IDLE: if (en_i && (start_i || cont_i)) state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (!en_i)          state_nxt = ST_IDLE;
                else if (edge_p)    state_nxt = ST_GATE;
                else if (gate_last) state_nxt = ST_DONE;
            end
            ST_GATE: begin
                if (!en_i)          state_nxt = ST_IDLE;
                else if (gate_last) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = (en_i && cont_i) ? ST_GATE : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        busy_o = (state == ST_SYNC) || (state == ST_GATE);
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_win  <= 1'b0;
            count_o  <= '0;
            valid_o  <= 1'b0;
            ovf_o    <= 1'b0;
            alive_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: gate_cnt <= '0;
                ST_SYNC: if (en_i) begin
                    if (edge_p) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_win  <= 1'b0;
                    end else if (gate_last) begin
                        gate_cnt <= '0;
                        count_o  <= '0;
                        ovf_o    <= 1'b0;
                        alive_o  <= 1'b0;
                        valid_o  <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                ST_GATE: if (en_i) begin
                    edge_cnt <= edge_inc;
                    ovf_win  <= ovf_inc;
                    if (gate_last) begin
                        gate_cnt <= '0;
                        count_o  <= edge_inc;
                        ovf_o    <= ovf_inc;
                        alive_o  <= (edge_inc != '0);
                        valid_o  <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                // DONE is cycle 0 of a back-to-back window, so the gate counter
                // resumes at 1 and an edge seen here is already counted.
                ST_DONE: begin
                    gate_cnt <= GW'(1);
                    edge_cnt <= CNT_W'(edge_p);
                    ovf_win  <= 1'b0;
                end
                default: gate_cnt <= '0;
            endcase
        end
    end

endmodule
